// File: rtl/dhcp_vlg_sequencer_if.sv
// ---------------------------------------------------------------------------
// dhcp_vlg_sequencer_if
// Frame-request / parsed-message bus between the DORA sequencer and the
// DHCP packet builder (TX side) and parser (RX side).
//   tx_req     : sequencer asks the builder for a frame, held until tx_ack
//   tx_type    : DHCP message type (1=Discover, 3=Request)
//   tx_req_ip  : requested IP (option 50)
//   tx_srv_ip  : server identifier (option 54, Request only)
//   xid        : current transaction ID
//   tx_ack     : builder accepted the frame (one cycle)
//   rx_val     : parsed message valid (one cycle)
//   rx_type    : 2=Offer, 5=Ack, 6=Nak
//   rx_xid     : transaction ID of the received message
//   rx_yiaddr  : offered / assigned IP
//   rx_srv_ip  : server identifier
//   rx_lease   : lease time in seconds, 0 if absent
// Modports: master = sequencer, slave = builder/parser side.
// ---------------------------------------------------------------------------
interface dhcp_vlg_sequencer_if;
    logic        tx_req;
    logic [7:0]  tx_type;
    logic [31:0] tx_req_ip;
    logic [31:0] tx_srv_ip;
    logic [31:0] xid;
    logic        tx_ack;
    logic        rx_val;
    logic [7:0]  rx_type;
    logic [31:0] rx_xid;
    logic [31:0] rx_yiaddr;
    logic [31:0] rx_srv_ip;
    logic [31:0] rx_lease;

    modport master (
        output tx_req, tx_type, tx_req_ip, tx_srv_ip, xid,
        input  tx_ack, rx_val, rx_type, rx_xid, rx_yiaddr, rx_srv_ip, rx_lease
    );

    modport slave (
        input  tx_req, tx_type, tx_req_ip, tx_srv_ip, xid,
        output tx_ack, rx_val, rx_type, rx_xid, rx_yiaddr, rx_srv_ip, rx_lease
    );
endinterface

// File: rtl/dhcp_vlg_sequencer.sv
// ---------------------------------------------------------------------------
// dhcp_vlg_sequencer
// Control FSM for the DHCP client DORA exchange (Discover, Offer, Request,
// Ack). Requests frames from the builder, consumes parsed messages, handles
// timeouts / retries, transaction-ID generation and (optionally) lease
// renewal.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : one-cycle pulse, begin DORA (accepted in IDLE/BOUND/FAIL)
//   pref_ip    : preferred IP, latched on start
//   assig_ip   : assigned IP, valid while success=1 (0 otherwise)
//   success    : lease bound
//   fail       : DORA failed, sticky until start or rst
//   ready      : idle and able to accept start
//   error      : one-cycle pulse on Nak, retry exhaustion or lease loss
//   bus        : builder/parser bus (dhcp_vlg_sequencer_if.master)
// Optional feature macro: DHCP_VLG_RENEW_EN
//   Defined   : lease timer, renewal at T1 (half lease), rebind on expiry/Nak.
//   Undefined : BOUND is terminal until start/rst, no lease timer logic.
// ---------------------------------------------------------------------------
module dhcp_vlg_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 62500000,
    parameter int unsigned RETRIES        = 3,
    parameter int unsigned SEC_CYCLES     = 125000000,
    parameter logic [31:0] XID_SEED       = 32'hA5C3_0001
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [31:0]                 pref_ip,
    output logic [31:0]                 assig_ip,
    output logic                        success,
    output logic                        fail,
    output logic                        ready,
    output logic                        error,
    dhcp_vlg_sequencer_if.master        bus
);

    typedef enum logic [3:0] {
        IDLE, DISC_TX, OFFER_WAIT, REQ_TX, ACK_WAIT, BOUND, FAIL_ST, RENEW_TX, RENEW_WAIT
    } state_t;

    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  RETRIES_L = 8'(RETRIES);

    // Galois LFSR, taps 32,22,2,1 (right-shifting form).
    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0000_0000);
    endfunction

    state_t      r_state, w_state_next;
    logic [31:0] r_xid, w_xid_next;
    logic [31:0] r_pref_ip, w_pref_next;
    logic [31:0] r_offer_ip, w_offer_next;
    logic [31:0] r_srv_ip, w_srv_next;
    logic [31:0] r_assig_ip, w_assig_next;
    logic [7:0]  r_retry, w_retry_next, w_retry_inc;
    logic [31:0] r_tmo_cnt;
    logic        r_success, w_success_next;
    logic        r_fail, w_fail_next;
    logic        r_error, w_error_next;
    logic        w_rx_ok, w_tmo, w_restart;

`ifdef DHCP_VLG_RENEW_EN
    localparam logic [31:0] SEC_LAST = 32'(SEC_CYCLES - 1);
    logic [31:0] r_lease, r_lease_rem, r_sec_cnt;
    logic [31:0] w_lease_new, w_rem_after;
    logic        w_load_lease, w_lease_run, w_sec_tick, w_lease_end, w_t1;

    assign w_lease_new = (bus.rx_lease == 32'd0) ? 32'hFFFF_FFFF : bus.rx_lease;
    // Infinite lease (all ones) never runs the timer.
    assign w_lease_run = (r_state == BOUND || r_state == RENEW_TX || r_state == RENEW_WAIT)
                         && (r_lease != 32'hFFFF_FFFF);
    assign w_sec_tick  = w_lease_run && (r_sec_cnt == SEC_LAST);
    assign w_rem_after = (w_sec_tick && r_lease_rem != 32'd0) ? r_lease_rem - 32'd1 : r_lease_rem;
    // Events are decided on the remaining count as it is being updated, so
    // the FSM reacts on the same edge the count reaches T1 / zero.
    assign w_lease_end = w_sec_tick && (w_rem_after == 32'd0);
    assign w_t1        = w_sec_tick && (w_rem_after == {1'b0, r_lease[31:1]});
`else
    logic w_unused_renew;
    assign w_unused_renew = (^bus.rx_lease) ^ (SEC_CYCLES != 0);
`endif

    assign w_rx_ok     = bus.rx_val && (bus.rx_xid == r_xid);
    assign w_tmo       = (r_tmo_cnt == TMO_LAST);
    assign w_retry_inc = r_retry + 8'd1;

    // Next-state / next-register logic.
    always_comb begin
        w_state_next   = r_state;
        w_xid_next     = r_xid;
        w_pref_next    = r_pref_ip;
        w_offer_next   = r_offer_ip;
        w_srv_next     = r_srv_ip;
        w_assig_next   = r_assig_ip;
        w_retry_next   = r_retry;
        w_success_next = r_success;
        w_fail_next    = r_fail;
        w_error_next   = 1'b0;
        w_restart      = 1'b0;
`ifdef DHCP_VLG_RENEW_EN
        w_load_lease   = 1'b0;
`endif
        if (start && (r_state == IDLE || r_state == BOUND || r_state == FAIL_ST)) begin
            w_state_next   = DISC_TX;
            w_xid_next     = lfsr_next(r_xid);
            w_pref_next    = pref_ip;
            w_retry_next   = 8'd0;
            w_success_next = 1'b0;
            w_fail_next    = 1'b0;
        end else begin
            case (r_state)
                DISC_TX:  if (bus.tx_ack) w_state_next = OFFER_WAIT;
                OFFER_WAIT: begin
                    if (w_rx_ok && bus.rx_type == 8'd2) begin
                        w_offer_next = bus.rx_yiaddr;
                        w_srv_next   = bus.rx_srv_ip;
                        w_retry_next = 8'd0;
                        w_state_next = REQ_TX;
                    end else if (w_tmo) begin
                        w_retry_next = w_retry_inc;
                        if (w_retry_inc <= RETRIES_L) begin
                            w_xid_next   = lfsr_next(r_xid);
                            w_state_next = DISC_TX;
                        end else begin
                            w_state_next = FAIL_ST;
                            w_fail_next  = 1'b1;
                            w_error_next = 1'b1;
                        end
                    end
                end
                REQ_TX:   if (bus.tx_ack) w_state_next = ACK_WAIT;
                ACK_WAIT: begin
                    if (w_rx_ok && bus.rx_type == 8'd5) begin
                        w_assig_next   = bus.rx_yiaddr;
                        w_success_next = 1'b1;
                        w_state_next   = BOUND;
`ifdef DHCP_VLG_RENEW_EN
                        w_load_lease   = 1'b1;
`endif
                    end else if (w_rx_ok && bus.rx_type == 8'd6) begin
                        w_restart = 1'b1;
                    end else if (w_tmo) begin
                        w_retry_next = w_retry_inc;
                        if (w_retry_inc <= RETRIES_L) begin
                            w_xid_next   = lfsr_next(r_xid);
                            w_state_next = REQ_TX;
                        end else begin
                            w_state_next = FAIL_ST;
                            w_fail_next  = 1'b1;
                            w_error_next = 1'b1;
                        end
                    end
                end
`ifdef DHCP_VLG_RENEW_EN
                BOUND: begin
                    if (w_lease_end)  w_restart    = 1'b1;
                    else if (w_t1)    w_state_next = RENEW_TX;
                end
                RENEW_TX: begin
                    if (w_lease_end)       w_restart    = 1'b1;
                    else if (bus.tx_ack)   w_state_next = RENEW_WAIT;
                end
                RENEW_WAIT: begin
                    if (w_rx_ok && bus.rx_type == 8'd5) begin
                        w_assig_next = bus.rx_yiaddr;
                        w_load_lease = 1'b1;
                        w_state_next = BOUND;
                    end else if ((w_rx_ok && bus.rx_type == 8'd6) || w_lease_end) begin
                        w_restart = 1'b1;
                    end else if (w_tmo) begin
                        // Renewal keeps retrying; only expiry ends it.
                        w_xid_next   = lfsr_next(r_xid);
                        w_state_next = RENEW_TX;
                    end
                end
`endif
                default: ;
            endcase
        end
        // Nak or lease loss: restart the exchange with a fresh transaction.
        if (w_restart) begin
            w_state_next   = DISC_TX;
            w_xid_next     = lfsr_next(r_xid);
            w_retry_next   = 8'd0;
            w_success_next = 1'b0;
            w_error_next   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_xid      <= XID_SEED;
            r_pref_ip  <= 32'd0;
            r_offer_ip <= 32'd0;
            r_srv_ip   <= 32'd0;
            r_assig_ip <= 32'd0;
            r_retry    <= 8'd0;
            r_tmo_cnt  <= 32'd0;
            r_success  <= 1'b0;
            r_fail     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_xid      <= w_xid_next;
            r_pref_ip  <= w_pref_next;
            r_offer_ip <= w_offer_next;
            r_srv_ip   <= w_srv_next;
            r_assig_ip <= w_assig_next;
            r_retry    <= w_retry_next;
            r_success  <= w_success_next;
            r_fail     <= w_fail_next;
            r_error    <= w_error_next;
            // Timeout counter restarts on every state entry, saturates otherwise.
            if (w_state_next != r_state)       r_tmo_cnt <= 32'd0;
            else if (r_tmo_cnt != 32'hFFFF_FFFF) r_tmo_cnt <= r_tmo_cnt + 32'd1;
        end
    end

`ifdef DHCP_VLG_RENEW_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lease     <= 32'd0;
            r_lease_rem <= 32'd0;
            r_sec_cnt   <= 32'd0;
        end else if (w_load_lease) begin
            r_lease     <= w_lease_new;
            r_lease_rem <= w_lease_new;
            r_sec_cnt   <= 32'd0;
        end else if (w_sec_tick) begin
            r_sec_cnt   <= 32'd0;
            r_lease_rem <= w_rem_after;
        end else if (w_lease_run) begin
            r_sec_cnt   <= r_sec_cnt + 32'd1;
        end
    end
`endif

    // Frame request fields are decoded from the registered state.
    always_comb begin
        bus.tx_req    = 1'b0;
        bus.tx_type   = 8'd0;
        bus.tx_req_ip = 32'd0;
        bus.tx_srv_ip = 32'd0;
        case (r_state)
            DISC_TX: begin
                bus.tx_req    = 1'b1;
                bus.tx_type   = 8'd1;
                bus.tx_req_ip = r_pref_ip;
            end
            REQ_TX: begin
                bus.tx_req    = 1'b1;
                bus.tx_type   = 8'd3;
                bus.tx_req_ip = r_offer_ip;
                bus.tx_srv_ip = r_srv_ip;
            end
            RENEW_TX: begin
                bus.tx_req    = 1'b1;
                bus.tx_type   = 8'd3;
                bus.tx_req_ip = r_assig_ip;
                bus.tx_srv_ip = r_srv_ip;
            end
            default: ;
        endcase
    end

    assign bus.xid  = r_xid;
    assign ready    = (r_state == IDLE);
    assign success  = r_success;
    assign fail     = r_fail;
    assign error    = r_error;
    assign assig_ip = r_success ? r_assig_ip : 32'd0;

endmodule

// File: tb/tb_dhcp_vlg_sequencer.sv
module tb_dhcp_vlg_sequencer;

    localparam int unsigned TMO  = 100;
    localparam int unsigned RTRY = 3;
    localparam int unsigned SECC = 10;
    localparam logic [31:0] SEED = 32'hA5C3_0001;
    localparam logic [31:0] PREF = 32'hC0A8_0164;
    localparam logic [31:0] SRV  = 32'hC0A8_0101;

    typedef struct {
        logic [7:0]  typ;
        logic [31:0] rip;
        logic [31:0] sip;
        logic [31:0] xid;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] pref_ip = 32'd0;
    logic [31:0] assig_ip;
    logic        success, fail, ready, error;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_mis = 0;
    frame_t      exp_q[$];
    logic [31:0] m_xid;

    dhcp_vlg_sequencer_if bus_if();

    dhcp_vlg_sequencer #(
        .TIMEOUT_CYCLES(TMO), .RETRIES(RTRY), .SEC_CYCLES(SECC), .XID_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pref_ip(pref_ip),
        .assig_ip(assig_ip), .success(success), .fail(fail),
        .ready(ready), .error(error), .bus(bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR: x^32 + x^22 + x^2 + x + 1, Galois right shift.
    function automatic logic [31:0] ref_lfsr(input logic [31:0] v);
        logic [31:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ ((32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1);
        return r;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] t, input logic [31:0] rip,
                              input logic [31:0] sip, input logic [31:0] x);
        frame_t f;
        f.typ = t; f.rip = rip; f.sip = sip; f.xid = x;
        exp_q.push_back(f);
    endtask

    // Wait for a frame request, score it against the queue, ack it.
    task automatic serve_frame(input string tag, output int seen);
        frame_t e;
        int n;
        n = 0;
        seen = -1;
        while (!bus_if.tx_req && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!bus_if.tx_req) begin
            check_val({tag, "_txreq_timeout"}, {31'd0, bus_if.tx_req}, 32'd1);
            return;
        end
        check_val({tag, "_sb_nonempty"}, (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        seen = cyc;
        $display("frame %s: type=%0d req_ip=%h srv_ip=%h xid=%h at cyc %0d",
                 tag, bus_if.tx_type, bus_if.tx_req_ip, bus_if.tx_srv_ip, bus_if.xid, cyc);
        check_val({tag, "_type"},   {24'd0, bus_if.tx_type}, {24'd0, e.typ});
        check_val({tag, "_req_ip"}, bus_if.tx_req_ip, e.rip);
        check_val({tag, "_srv_ip"}, bus_if.tx_srv_ip, e.sip);
        check_val({tag, "_xid"},    bus_if.xid, e.xid);
        bus_if.tx_ack = 1'b1;
        @(negedge clk);
        bus_if.tx_ack = 1'b0;
        check_val({tag, "_txreq_drop"}, {31'd0, bus_if.tx_req}, 32'd0);
    endtask

    task automatic send_rx(input logic [7:0] t, input logic [31:0] x, input logic [31:0] yi,
                           input logic [31:0] sv, input logic [31:0] lease);
        $display("rx: type=%0d xid=%h yiaddr=%h srv=%h lease=%0d at cyc %0d", t, x, yi, sv, lease, cyc);
        bus_if.rx_val = 1'b1; bus_if.rx_type = t; bus_if.rx_xid = x;
        bus_if.rx_yiaddr = yi; bus_if.rx_srv_ip = sv; bus_if.rx_lease = lease;
        @(negedge clk);
        bus_if.rx_val = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] ip);
        m_xid = ref_lfsr(m_xid);
        push_frame(8'd1, ip, 32'd0, m_xid);
        pref_ip = ip;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pref_ip = 32'hDEAD_BEEF;   // must have been latched
        $display("start: pref_ip=%h at cyc %0d", ip, cyc);
    endtask

    // Discover, Offer, Request up to ACK_WAIT.
    task automatic to_ack_wait(input string tag);
        int s;
        serve_frame({tag, "_disc"}, s);
        push_frame(8'd3, PREF, SRV, m_xid);
        send_rx(8'd2, m_xid, PREF, SRV, 32'd0);
        serve_frame({tag, "_req"}, s);
    endtask

    initial begin
        int s0, s1, b, n, err_cnt, txr_cnt;
        logic [31:0] old_xid;
        bus_if.tx_ack = 1'b0; bus_if.rx_val = 1'b0; bus_if.rx_type = 8'd0;
        bus_if.rx_xid = 32'd0; bus_if.rx_yiaddr = 32'd0; bus_if.rx_srv_ip = 32'd0;
        bus_if.rx_lease = 32'd0;
        m_xid = SEED;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_ready",   {31'd0, ready},   32'd1);
        check_val("rst_success", {31'd0, success}, 32'd0);
        check_val("rst_fail",    {31'd0, fail},    32'd0);
        check_val("rst_error",   {31'd0, error},   32'd0);
        check_val("rst_tx_req",  {31'd0, bus_if.tx_req}, 32'd0);
        check_val("rst_xid",     bus_if.xid, SEED);
        check_val("rst_assig",   assig_ip, 32'd0);

        // Full DORA
        do_start(PREF);
        check_val("dora_ready_low", {31'd0, ready}, 32'd0);
        to_ack_wait("dora");
        send_rx(8'd5, m_xid, PREF, SRV, 32'd3600);
        check_val("dora_success", {31'd0, success}, 32'd1);
        check_val("dora_assig",   assig_ip, PREF);
        check_val("dora_ready",   {31'd0, ready}, 32'd0);

        // Wrong-XID Offer ignored, timeout retransmits with new xid
        do_start(PREF);
        check_val("restart_success_clr", {31'd0, success}, 32'd0);
        serve_frame("badxid_disc", s0);
        send_rx(8'd2, m_xid ^ 32'd1, PREF, SRV, 32'd0);
        m_xid = ref_lfsr(m_xid);
        push_frame(8'd1, PREF, 32'd0, m_xid);
        serve_frame("retry_disc", s1);
        check_val("timeout_delay", 32'(s1 - s0), 32'(TMO + 1));
        push_frame(8'd3, PREF, SRV, m_xid);
        send_rx(8'd2, m_xid, PREF, SRV, 32'd0);
        serve_frame("retry_req", s0);
        send_rx(8'd5, m_xid, PREF, SRV, 32'd60);
        check_val("retry_success", {31'd0, success}, 32'd1);

        // No reply: 4 Discovers then FAIL
        do_start(PREF);
        serve_frame("nr_disc0", s0);
        for (int i = 1; i <= int'(RTRY); i++) begin
            m_xid = ref_lfsr(m_xid);
            push_frame(8'd1, PREF, 32'd0, m_xid);
            serve_frame($sformatf("nr_disc%0d", i), s0);
        end
        err_cnt = 0; txr_cnt = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (error) err_cnt++;
            if (bus_if.tx_req) txr_cnt++;
        end
        check_val("nr_error_pulses", 32'(err_cnt), 32'd1);
        check_val("nr_extra_txreq",  32'(txr_cnt), 32'd0);
        check_val("nr_fail",    {31'd0, fail},    32'd1);
        check_val("nr_success", {31'd0, success}, 32'd0);

        // Nak in ACK_WAIT
        do_start(PREF);
        check_val("nak_fail_clr", {31'd0, fail}, 32'd0);
        to_ack_wait("nak");
        old_xid = m_xid;
        send_rx(8'd6, m_xid, 32'd0, SRV, 32'd0);
        check_val("nak_error", {31'd0, error}, 32'd1);
        check_val("nak_xid_changed", (bus_if.xid != old_xid) ? 32'd1 : 32'd0, 32'd1);
        m_xid = ref_lfsr(m_xid);
        push_frame(8'd1, PREF, 32'd0, m_xid);
        to_ack_wait("after_nak");

        // Reset while in ACK_WAIT
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_xid = SEED;
        check_val("mid_rst_ready",  {31'd0, ready}, 32'd1);
        check_val("mid_rst_tx_req", {31'd0, bus_if.tx_req}, 32'd0);
        check_val("mid_rst_xid",    bus_if.xid, SEED);

        // Lease handling
        do_start(PREF);
        to_ack_wait("lease");
        send_rx(8'd5, m_xid, PREF, SRV, 32'd8);
        b = cyc;
        check_val("lease_bound", {31'd0, success}, 32'd1);
`ifdef DHCP_VLG_RENEW_EN
        push_frame(8'd3, PREF, SRV, m_xid);
        serve_frame("renew_req", s0);
        check_val("renew_t1_delay", 32'(s0 - b), 32'd40);
        n = 0;
        while (success && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val("expiry_delay", 32'(cyc - b), 32'd80);
        check_val("expiry_error", {31'd0, error}, 32'd1);
        m_xid = ref_lfsr(m_xid);
        push_frame(8'd1, PREF, 32'd0, m_xid);
        serve_frame("rebind_disc", s0);
`else
        txr_cnt = 0; n = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (bus_if.tx_req) txr_cnt++;
            if (!success) n++;
        end
        check_val("bound_no_txreq", 32'(txr_cnt), 32'd0);
        check_val("bound_stays",    32'(n), 32'd0);
`endif
        check_val("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
